// File: rtl/clock_edge_receiver.sv
// clock_edge_receiver: synchronises an external serial clock/data pair to
// CLK50MHZ, glitch-filters the clock, emits rise/fall pulses and assembles
// DATA_W-bit words (MSB first) with an idle timeout.
// Optional build macro CLOCK_EDGE_RECEIVER_PERIOD_EN enables the
// sampling-edge period counter; otherwise period is tied to zero.
module clock_edge_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT        = 5000,
  parameter bit          SAMPLE_ON_FALL = 1'b0,
  parameter bit          IDLE_LEVEL     = 1'b0
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic              ext_clk,
  input  logic              ext_data,
  output logic              clk_level,
  output logic              clk_rise,
  output logic              clk_fall,
  output logic [DATA_W-1:0] data_word,
  output logic              data_valid,
  output logic              busy,
  output logic              timeout,
  output logic [15:0]       period
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [FILTER_LEN-1:0] dly_q, dly_d;
  logic [0:0] state_q, state_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic valid_q, valid_d, tout_q, tout_d, busy_q, busy_d;
  logic dly_bit, samp, any_edge;
  logic [DATA_W-1:0] shifted;

  assign dly_bit  = dly_q[FILTER_LEN-1];
  assign samp     = SAMPLE_ON_FALL ? fall_q : rise_q;
  assign any_edge = rise_q | fall_q;
  assign shifted  = {shift_q, dly_bit};

  // Glitch filter: level toggles after FILTER_LEN consecutive differing samples
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    fcnt_d  = '0;
    if (clk_s2_q != level_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  // Data delay line keeps the sampled bit aligned with the filtered edge
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = data_s2_q;
    for (int i = 1; i < int'(FILTER_LEN); i++) dly_d[i] = dly_q[i-1];
  end

  // Receive FSM: shift on sampling edges, deliver word or time out
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    word_d  = word_q;
    valid_d = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        to_d   = '0;
        if (samp) begin
          shift_d = (DATA_W-1)'(dly_bit);
          bcnt_d  = BCNT_W'(1);
          state_d = S_RECV;
        end
      end
      default: begin
        if (samp) begin
          to_d = '0;
          if (bcnt_q == BCNT_W'(DATA_W - 1)) begin
            word_d  = shifted;
            valid_d = 1'b1;
            shift_d = '0;
            bcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            shift_d = shifted[DATA_W-2:0];
            bcnt_d  = bcnt_q + BCNT_W'(1);
          end
        end else if (any_edge) begin
          to_d = '0;
        end else if (to_q == TO_W'(TIMEOUT - 2)) begin
          tout_d  = 1'b1;
          shift_d = '0;
          bcnt_d  = '0;
          to_d    = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
    endcase
    busy_d = (state_d == S_RECV);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      clk_s1_q  <= IDLE_LEVEL;
      clk_s2_q  <= IDLE_LEVEL;
      data_s1_q <= 1'b0;
      data_s2_q <= 1'b0;
      level_q   <= IDLE_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fcnt_q    <= '0;
      dly_q     <= '0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bcnt_q    <= '0;
      to_q      <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      tout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      clk_s1_q  <= ext_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ext_data;
      data_s2_q <= data_s1_q;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      fcnt_q    <= fcnt_d;
      dly_q     <= dly_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
      to_q      <= to_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      tout_q    <= tout_d;
      busy_q    <= busy_d;
    end
  end

`ifdef CLOCK_EDGE_RECEIVER_PERIOD_EN
  logic [15:0] pcnt_q, pcnt_d, period_q, period_d;
  logic pfirst_q, pfirst_d;

  // Saturating cycle count between consecutive sampling edges
  always_comb begin
    pcnt_d   = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
    period_d = period_q;
    pfirst_d = pfirst_q;
    if (samp) begin
      pcnt_d   = '0;
      pfirst_d = 1'b1;
      if (pfirst_q) period_d = (pcnt_q == 16'hFFFF) ? 16'hFFFF : pcnt_q + 16'd1;
    end
  end

  // Period registers, cleared only by reset
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      pcnt_q   <= '0;
      period_q <= '0;
      pfirst_q <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pfirst_q <= pfirst_d;
    end
  end

  assign period = period_q;
`else
  assign period = 16'h0000;
`endif

  assign clk_level  = level_q;
  assign clk_rise   = rise_q;
  assign clk_fall   = fall_q;
  assign data_word  = word_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign timeout    = tout_q;

endmodule

// File: tb/tb_clock_edge_receiver.sv
// Scoreboard bench for clock_edge_receiver (defaults, TIMEOUT=200).
module tb_clock_edge_receiver;

  localparam int unsigned TO_CYC = 200;

  logic CLK50MHZ = 1'b0;
  logic RST, ext_clk, ext_data;
  logic clk_level, clk_rise, clk_fall, data_valid, busy, timeout;
  logic [7:0] data_word;
  logic [15:0] period;

  clock_edge_receiver #(.TIMEOUT(TO_CYC)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .ext_clk(ext_clk), .ext_data(ext_data),
    .clk_level(clk_level), .clk_rise(clk_rise), .clk_fall(clk_fall),
    .data_word(data_word), .data_valid(data_valid), .busy(busy),
    .timeout(timeout), .period(period)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  typedef struct packed {
    logic       is_to;
    logic [7:0] word;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int valid_cnt = 0;
  int last_edge_cyc = 0;

  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK50MHZ);
  endtask

  // Bits hi..lo of v, MSB first; data changes with the falling clock, 40-cycle period
  task automatic send_bits(input logic [7:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      ext_data = v[i];
      ext_clk  = 1'b0;
      cycles(20);
      ext_clk  = 1'b1;
      cycles(20);
    end
    ext_clk = 1'b0;
  endtask

  // Monitor: pops expected events when the DUT presents data_valid or timeout
  always @(negedge CLK50MHZ) begin
    if (RST) begin
      if (clk_rise) rise_cnt++;
      if (clk_fall) fall_cnt++;
      if (data_valid) begin
        valid_cnt++;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got word %0h expected no event", data_word);
        end else begin
          mon_e = expq.pop_front();
          check("valid_kind", 32'(mon_e.is_to), 32'(1'b0));
          check("data_word", 32'(data_word), 32'(mon_e.word));
        end
      end
      if (timeout) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_timeout: got timeout expected no event");
        end else begin
          mon_e = expq.pop_front();
          check("timeout_kind", 32'(mon_e.is_to), 32'(1'b1));
          check("timeout_word_kept", 32'(data_word), 32'(mon_e.word));
          check("timeout_busy", 32'(busy), 32'(1'b0));
          check("timeout_delay", 32'(cyc - last_edge_cyc), TO_CYC);
        end
      end
      if (clk_rise || clk_fall) last_edge_cyc = cyc;
    end
  end

  initial begin
    int lat;
    int r0;
    int f0;
    int v0;
    RST = 1'b0; ext_clk = 1'b0; ext_data = 1'b0;
    cycles(10);
    RST = 1'b1;
    check("rst_level", 32'(clk_level), 32'(0));
    check("rst_rise", 32'(clk_rise), 32'(0));
    check("rst_fall", 32'(clk_fall), 32'(0));
    check("rst_word", 32'(data_word), 32'(0));
    check("rst_valid", 32'(data_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    check("rst_period", 32'(period), 32'(0));
    cycles(50);
    check("idle_no_pulses", 32'(rise_cnt + fall_cnt), 32'(0));

    // 3-cycle glitch is rejected
    ext_clk = 1'b1; cycles(3); ext_clk = 1'b0; cycles(20);
    check("glitch_rejected", 32'(rise_cnt), 32'(0));
    check("glitch_level", 32'(clk_level), 32'(0));

    // 4-cycle pulse: one rise after FILTER_LEN+2 cycles, then one fall; one bit -> timeout
    expq.push_back('{is_to: 1'b1, word: 8'h00});
    r0 = rise_cnt; f0 = fall_cnt; lat = 0;
    ext_clk = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK50MHZ);
      if (clk_rise && lat == 0) lat = i;
      if (i == 4) ext_clk = 1'b0;
    end
    check("rise_latency", 32'(lat), 32'(6));
    cycles(300);
    check("single_rise", 32'(rise_cnt - r0), 32'(1));
    check("single_fall", 32'(fall_cnt - f0), 32'(1));
    check("after_timeout_busy", 32'(busy), 32'(0));

    // Full frame 0xA5
    v0 = valid_cnt;
    expq.push_back('{is_to: 1'b0, word: 8'hA5});
    send_bits(8'hA5, 7, 4);
    check("busy_mid_frame", 32'(busy), 32'(1));
    send_bits(8'hA5, 3, 0);
    cycles(30);
    check("busy_after_frame", 32'(busy), 32'(0));
    check("a5_valid_count", 32'(valid_cnt - v0), 32'(1));
`ifdef CLOCK_EDGE_RECEIVER_PERIOD_EN
    check("period_40", 32'(period), 32'(40));
`else
    check("period_off", 32'(period), 32'(0));
`endif

    // Partial frame times out, word kept; next frame 0x3C
    expq.push_back('{is_to: 1'b1, word: 8'hA5});
    send_bits(8'hA0, 7, 5);
    cycles(260);
    check("partial_busy", 32'(busy), 32'(0));
    check("partial_word", 32'(data_word), 32'(8'hA5));
    expq.push_back('{is_to: 1'b0, word: 8'h3C});
    send_bits(8'h3C, 7, 0);
    cycles(30);

    // Reset mid-frame, then 0x81
    v0 = valid_cnt;
    send_bits(8'hFF, 7, 3);
    RST = 1'b0;
    cycles(10);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_word", 32'(data_word), 32'(0));
    RST = 1'b1;
    expq.push_back('{is_to: 1'b0, word: 8'h81});
    send_bits(8'h81, 7, 0);
    cycles(30);
    check("midrst_valid_count", 32'(valid_cnt - v0), 32'(1));
    check("final_word", 32'(data_word), 32'(8'h81));

    for (int i = 0; i < 1000 && expq.size() > 0; i++) cycles(1);
    check("queue_drained", 32'(expq.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
